// File: rtl/eight_bit_restoring_divider.sv
// Multi-cycle unsigned 16/8 restoring divider with valid/ready handshakes on both sides.
// One quotient bit per clock; a zero divisor short-circuits to a saturated quotient.
module eight_bit_restoring_divider (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [15:0] dividend_in,
  input  logic [7:0]  divisor_in,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [15:0] quotient_out,
  output logic [7:0]  remainder_out,
  output logic        div_by_zero
);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t      state_q, state_d;
  logic [3:0]  count_q, count_d;
  logic [8:0]  rem_q, rem_d;
  logic [15:0] dvd_q, dvd_d;
  logic [7:0]  dvsr_q, dvsr_d;
  logic [15:0] quot_q, quot_d;
  logic [7:0]  remo_q, remo_d;
  logic        dbz_q, dbz_d;

  // One restoring step: dvd_q shifts its MSB into the remainder and takes the
  // new quotient bit at its LSB, so after 16 steps it holds the quotient.
  logic [9:0]  rem_wide;
  logic        fits;
  logic [8:0]  rem_step;
  logic [15:0] dvd_step;

  always_comb begin
    rem_wide = {rem_q, dvd_q[15]};
    fits     = (rem_wide >= {2'b00, dvsr_q});
    rem_step = fits ? 9'(rem_wide - {2'b00, dvsr_q}) : rem_wide[8:0];
    dvd_step = {dvd_q[14:0], fits};
  end

  always_comb begin
    // NOTE: every _d gets its hold value first so no path through this block infers a latch.
    state_d = state_q;
    count_d = count_q;
    rem_d   = rem_q;
    dvd_d   = dvd_q;
    dvsr_d  = dvsr_q;
    quot_d  = quot_q;
    remo_d  = remo_q;
    dbz_d   = dbz_q;

    unique case (state_q)
      IDLE: begin
        if (in_valid) begin
          if (divisor_in == 8'd0) begin
            state_d = DONE;
            quot_d  = 16'hFFFF;
            remo_d  = 8'h00;
            dbz_d   = 1'b1;
          end else begin
            state_d = BUSY;
            count_d = 4'd0;
            rem_d   = 9'd0;
            dvd_d   = dividend_in;
            dvsr_d  = divisor_in;
            dbz_d   = 1'b0;
          end
        end
      end
      BUSY: begin
        rem_d   = rem_step;
        dvd_d   = dvd_step;
        count_d = count_q + 4'd1;
        if (count_q == 4'd15) begin
          state_d = DONE;
          quot_d  = dvd_step;
          remo_d  = rem_step[7:0];
        end
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      count_q <= 4'd0;
      rem_q   <= 9'd0;
      dvd_q   <= 16'd0;
      dvsr_q  <= 8'd0;
      quot_q  <= 16'd0;
      remo_q  <= 8'd0;
      dbz_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      rem_q   <= rem_d;
      dvd_q   <= dvd_d;
      dvsr_q  <= dvsr_d;
      quot_q  <= quot_d;
      remo_q  <= remo_d;
      dbz_q   <= dbz_d;
    end
  end

  assign in_ready      = (state_q == IDLE);
  assign out_valid     = (state_q == DONE);
  assign quotient_out  = quot_q;
  assign remainder_out = remo_q;
  assign div_by_zero   = dbz_q;

endmodule

// File: tb/tb_eight_bit_restoring_divider.sv
// Scoreboard bench for eight_bit_restoring_divider: directed vectors, stall/hold,
// mid-operation reset and random traffic with latency checking.
module tb_eight_bit_restoring_divider;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] dividend_in;
  logic [7:0]  divisor_in;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] quotient_out;
  logic [7:0]  remainder_out;
  logic        div_by_zero;

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    logic [15:0] q;
    logic [7:0]  r;
    logic        dbz;
    int          lat;
  } exp_t;

  exp_t exp_q[$];

  eight_bit_restoring_divider dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .dividend_in  (dividend_in),
    .divisor_in   (divisor_in),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .quotient_out (quotient_out),
    .remainder_out(remainder_out),
    .div_by_zero  (div_by_zero)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
    end
  endtask

  task automatic wait_ready();
    int guard = 0;
    while (!in_ready && guard < 50) begin
      @(posedge clk); #1;
      guard++;
    end
    check("wait_in_ready", 32'(in_ready), 32'd1);
  endtask

  // Latency is counted in rising edges after the accepting edge until out_valid
  // is seen; a zero-divisor result is already visible in the cycle right after accept.
  task automatic run_op(input logic [15:0] a, input logic [7:0] b, input int stall, input bit poke);
    exp_t e;
    int   lat;
    int unsigned lhs;
    wait_ready();
    e.q   = (b == 8'd0) ? 16'hFFFF : a / 16'(b);
    e.r   = (b == 8'd0) ? 8'h00 : 8'(a % 16'(b));
    e.dbz = (b == 8'd0);
    e.lat = (b == 8'd0) ? 0 : 16;
    exp_q.push_back(e);

    dividend_in = a;
    divisor_in  = b;
    in_valid    = 1'b1;
    @(posedge clk); #1;
    in_valid = poke;
    if (poke) begin
      dividend_in = 16'h1234;
      divisor_in  = 8'h01;
    end

    lat = 0;
    while (!out_valid && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
    check("out_valid_seen", 32'(out_valid), 32'd1);
    if (exp_q.size() == 0) begin
      check("scoreboard_empty", 32'd0, 32'd1);
    end else begin
      e = exp_q.pop_front();
      check("latency", 32'(lat), 32'(e.lat));
      check("quotient", 32'(quotient_out), 32'(e.q));
      check("remainder", 32'(remainder_out), 32'(e.r));
      check("div_by_zero", 32'(div_by_zero), 32'(e.dbz));
      if (b != 8'd0) begin
        lhs = 32'(quotient_out) * 32'(b) + 32'(remainder_out);
        check("q*d+r", lhs, 32'(a));
        check("r_lt_d", 32'(remainder_out < b), 32'd1);
      end

      for (int i = 0; i < stall; i++) begin
        @(posedge clk); #1;
        check("hold_valid", 32'(out_valid), 32'd1);
        check("hold_in_ready", 32'(in_ready), 32'd0);
        check("hold_q", 32'(quotient_out), 32'(e.q));
        check("hold_r", 32'(remainder_out), 32'(e.r));
      end

      in_valid  = 1'b0;
      out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;
      check("post_hs_valid", 32'(out_valid), 32'd0);
      check("post_hs_in_ready", 32'(in_ready), 32'd1);
      check("post_hs_q_kept", 32'(quotient_out), 32'(e.q));
    end
  endtask

  initial begin
    bit saw_valid;
    rst_n       = 1'b0;
    in_valid    = 1'b0;
    out_ready   = 1'b0;
    dividend_in = 16'd0;
    divisor_in  = 8'd0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_q", 32'(quotient_out), 32'd0);
    check("rst_r", 32'(remainder_out), 32'd0);
    check("rst_dbz", 32'(div_by_zero), 32'd0);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("first_cycle_in_ready", 32'(in_ready), 32'd1);

    run_op(16'd200,   8'd7,   0, 1'b0);
    run_op(16'd14400, 8'd120, 0, 1'b0);
    run_op(16'd65535, 8'd1,   0, 1'b0);
    run_op(16'd65535, 8'd255, 0, 1'b0);
    run_op(16'd0,     8'd13,  1, 1'b0);
    run_op(16'd5,     8'd200, 0, 1'b0);
    run_op(16'd100,   8'd0,   2, 1'b0);
    run_op(16'd9,     8'd3,   0, 1'b0);
    run_op(16'd200,   8'd7,   5, 1'b1);

    // Abort 200/7 part-way through BUSY; previous outputs (q=28) must clear.
    wait_ready();
    dividend_in = 16'd200;
    divisor_in  = 8'd7;
    in_valid    = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (8) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("abort_q", 32'(quotient_out), 32'd0);
    check("abort_r", 32'(remainder_out), 32'd0);
    check("abort_dbz", 32'(div_by_zero), 32'd0);
    check("abort_out_valid", 32'(out_valid), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("abort_in_ready", 32'(in_ready), 32'd1);
    saw_valid = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      saw_valid |= out_valid;
    end
    check("abort_no_out_valid", 32'(saw_valid), 32'd0);
    run_op(16'd50, 8'd5, 0, 1'b0);

    for (int i = 0; i < 1000; i++) begin
      run_op(16'($urandom), 8'($urandom_range(1, 255)), int'($urandom_range(0, 3)), 1'b0);
    end

    check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
